ahblite_interconnect: RTL
=========================

# ahblite_interconnect

Parametrised AHB-Lite single-master interconnect for the Cortex-M0 subsystem. It replaces the fixed seven-port combinational address decoder with an N-port decoder driven by base/mask parameters, plus a data-phase response multiplexer. It also contains a built-in default slave that returns a two-cycle ERROR for unmapped accesses and logs them in a saturating error counter with last-error address capture. It sits between the core's AHB master port and all memory and peripheral slaves (RAMCODE, RAMDATA, LCD, UART, Camera, LED, Buzzer).

## Interface
- NUM_PORTS, 7: slave port count, 1..16.
- PORT_BASE, {0x40060000, 0x40040000, 0x40300000, 0x40000010, 0x40050000, 0x20000000, 0x00000000}: packed 32*NUM_PORTS base addresses; port i occupies bits [32i+31:32i].
- PORT_MASK, {0xFFFF0000, 0xFFFF0000, 0xFFF00000, 0xFFFFFFF0, 0xFFFF0000, 0xFFFF0000, 0xFFFF0000}: packed 32*NUM_PORTS compare masks.
- PORT_EN, 7'h7F: per-port enable; a disabled port never hits.
- ERR_CNT_W, 8: error counter width.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  asynchronous, active-high reset.
- HADDR  in  32  master address, address phase.
- HTRANS  in  2  master transfer type.
- S_HSEL  out  NUM_PORTS  per-slave select, address phase.
- S_HREADYOUT  in  NUM_PORTS  per-slave ready.
- S_HRESP  in  NUM_PORTS  per-slave response.
- S_HRDATA  in  32*NUM_PORTS  per-slave read data.
- HREADY  out  1  muxed ready; goes to the master and to every slave's HREADY input.
- HRESP  out  1  muxed response to the master.
- HRDATA  out  32  muxed read data to the master.
- ERR_CLR  in  1  synchronous clear of the error log.
- ERR_COUNT  out  ERR_CNT_W  count of unmapped transfers, saturating.
- ERR_ADDR  out  32  HADDR of the most recent unmapped transfer.

## Operation
- Hit rule: hit[i] = PORT_EN[i] & ((HADDR & PORT_MASK[i]) == PORT_BASE[i]).
- Overlapping hits: the lowest index wins, so S_HSEL is one-hot or zero.
- S_HSEL is purely combinational from HADDR and is independent of HTRANS. IDLE transfers still select; slaves ignore them per the AHB-Lite protocol.
- Data-phase register: dp_sel <= S_HSEL on every rising HCLK edge with HREADY=1, and holds otherwise.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE -> DS_ERR1 on an edge with HREADY=1, HTRANS[1]=1 and no hit.
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if the address phase sampled at that edge is another unmapped NONSEQ/SEQ; otherwise -> DS_IDLE.
- Default-slave outputs:
  - DS_IDLE: ready=1, resp=OKAY. Unmapped IDLE/BUSY transfers complete zero-wait OKAY.
  - DS_ERR1: ready=0, resp=ERROR.
  - DS_ERR2: ready=1, resp=ERROR.
- Response mux (AND-OR form):
  - If any dp_sel bit is set, HREADY/HRESP/HRDATA come from the selected slave.
  - Otherwise they come from the default slave, with HRDATA=0.
- Error log:
  - On each DS_IDLE/DS_ERR2 -> DS_ERR1 transition, ERR_COUNT increments, saturating at all-ones, and ERR_ADDR captures HADDR.
  - ERR_CLR zeroes both registers.
  - ERR_CLR coincident with a new error: count=1 and ERR_ADDR=new address (the error wins over the clear for the address).

## Timing
- Reset values: dp_sel=0, FSM=DS_IDLE, ERR_COUNT=0, ERR_ADDR=0. Consequently HREADY=1, HRESP=0, HRDATA=0 during and after reset.
- Reset asserted mid-transfer aborts immediately and returns all outputs to their reset values; there is no pending state.
- S_HSEL: 0-cycle (combinational) from HADDR.
- Response mux: 0-cycle from the slave inputs.
- Unmapped NONSEQ: exactly 2 data-phase cycles (one wait state, then ERROR with HREADY=1).
- Slave wait states propagate unchanged. dp_sel cannot change while HREADY=0, so the response source is stable for the whole data phase.
- Back-to-back mapped -> unmapped -> mapped transfers incur no bubble beyond the ERROR cycles.

## Structure
- Shared header ahb_defs.vh holds:
  - HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP codes (OKAY, ERROR);
  - the default system memory-map base/mask constants, which the top level uses to build PORT_BASE/PORT_MASK.
- One sub-module, ahblite_default_slave: the 3-state FSM plus its ready/resp outputs. The error log stays in the top module.

## Test plan
- Reset release, then NONSEQ read at 0x20000010 with RAMDATA returning 0xDEADBEEF -> S_HSEL=7'b0000010; next cycle HRDATA=0xDEADBEEF, HRESP=OKAY.
- UART at 0x40000014 (hit) and at 0x40000020 (miss) -> port 3 selected, then default slave: HREADY 0 then 1, HRESP=ERROR for both cycles, ERR_COUNT=1, ERR_ADDR=0x40000020.
- LCD slave holds S_HREADYOUT=0 for 3 cycles while HADDR moves to 0x00000100 -> HREADY=0 for 3 cycles, dp_sel stays on port 2, HRDATA is taken from LCD.
- IDLE transfer at unmapped 0x50000000 -> HREADY=1 and HRESP=OKAY with zero wait; ERR_COUNT unchanged.
- Error-log boundaries:
  - 300 consecutive unmapped NONSEQs -> ERR_COUNT saturates at 255.
  - ERR_CLR pulsed on the same edge as a new error at 0x60000000 -> ERR_COUNT=1, ERR_ADDR=0x60000000.
- HRESET asserted during DS_ERR1 -> HREADY=1, HRESP=0, ERR_COUNT=0 asynchronously; first post-reset mapped access completes normally.

Source files
------------

// File: rtl/ahblite_interconnect_pkg.sv
// Shared AHB-Lite definitions: transfer/response codes, the system memory map
// and the default-slave state encoding.
package ahblite_interconnect_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // System memory map, one base/mask pair per slave
    localparam logic [31:0] MAP_RAMCODE_BASE = 32'h0000_0000;
    localparam logic [31:0] MAP_RAMCODE_MASK = 32'hFFFF_0000;
    localparam logic [31:0] MAP_RAMDATA_BASE = 32'h2000_0000;
    localparam logic [31:0] MAP_RAMDATA_MASK = 32'hFFFF_0000;
    localparam logic [31:0] MAP_LCD_BASE     = 32'h4005_0000;
    localparam logic [31:0] MAP_LCD_MASK     = 32'hFFFF_0000;
    localparam logic [31:0] MAP_UART_BASE    = 32'h4000_0010;
    localparam logic [31:0] MAP_UART_MASK    = 32'hFFFF_FFF0;
    localparam logic [31:0] MAP_CAMERA_BASE  = 32'h4030_0000;
    localparam logic [31:0] MAP_CAMERA_MASK  = 32'hFFF0_0000;
    localparam logic [31:0] MAP_LED_BASE     = 32'h4004_0000;
    localparam logic [31:0] MAP_LED_MASK     = 32'hFFFF_0000;
    localparam logic [31:0] MAP_BUZZER_BASE  = 32'h4006_0000;
    localparam logic [31:0] MAP_BUZZER_MASK  = 32'hFFFF_0000;

    localparam int unsigned DEFAULT_NUM_PORTS = 7;

    // Port 0 sits in the least significant word
    localparam logic [32*DEFAULT_NUM_PORTS-1:0] DEFAULT_PORT_BASE = {
        MAP_BUZZER_BASE, MAP_LED_BASE, MAP_CAMERA_BASE, MAP_UART_BASE,
        MAP_LCD_BASE, MAP_RAMDATA_BASE, MAP_RAMCODE_BASE
    };
    localparam logic [32*DEFAULT_NUM_PORTS-1:0] DEFAULT_PORT_MASK = {
        MAP_BUZZER_MASK, MAP_LED_MASK, MAP_CAMERA_MASK, MAP_UART_MASK,
        MAP_LCD_MASK, MAP_RAMDATA_MASK, MAP_RAMCODE_MASK
    };

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // Data-phase response as seen by the master
    typedef struct packed {
        logic              ready;
        logic              resp;
        logic [DATA_W-1:0] rdata;
    } ahb_rsp_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for active transfers,
// zero-wait OKAY otherwise.
module ahblite_default_slave
    import ahblite_interconnect_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hready,
    input  logic trans_active,
    input  logic hit_any,
    output logic ready,
    output logic resp,
    output logic err_start_c
);

    ds_state_t state;
    ds_state_t state_next;
    logic      req_c;

    // An unmapped NONSEQ/SEQ address phase accepted at this edge
    assign req_c = hready & trans_active & ~hit_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DS_IDLE: if (req_c) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = req_c ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b1;
        resp        = HRESP_OKAY;
        err_start_c = 1'b0;
        case (state)
            DS_IDLE: begin
                err_start_c = req_c;
            end
            DS_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            DS_ERR2: begin
                resp        = HRESP_ERROR;
                err_start_c = req_c;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_interconnect.sv
// N-port AHB-Lite address decoder and data-phase response mux with a built-in
// default slave and an unmapped-access error log.
module ahblite_interconnect
    import ahblite_interconnect_pkg::*;
#(
    parameter int unsigned                NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter logic [32*NUM_PORTS-1:0]    PORT_BASE = DEFAULT_PORT_BASE,
    parameter logic [32*NUM_PORTS-1:0]    PORT_MASK = DEFAULT_PORT_MASK,
    parameter logic [NUM_PORTS-1:0]       PORT_EN   = {NUM_PORTS{1'b1}},
    parameter int unsigned                ERR_CNT_W = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    output logic [NUM_PORTS-1:0]      S_HSEL,
    input  logic [NUM_PORTS-1:0]      S_HREADYOUT,
    input  logic [NUM_PORTS-1:0]      S_HRESP,
    input  logic [DATA_W*NUM_PORTS-1:0] S_HRDATA,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    input  logic                      ERR_CLR,
    output logic [ERR_CNT_W-1:0]      ERR_COUNT,
    output logic [ADDR_W-1:0]         ERR_ADDR
);

    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] dp_sel;
    logic                 hit_any;
    logic                 trans_active;
    logic                 ds_ready;
    logic                 ds_resp;
    logic                 err_start_c;
    ahb_rsp_t             rsp;

    // Address decode; lowest index wins on overlap
    always_comb begin
        logic found;
        found  = 1'b0;
        hit    = '0;
        S_HSEL = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            hit[i] = PORT_EN[i] & ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
            if (hit[i] && !found) begin
                S_HSEL[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign hit_any      = |hit;
    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    ahblite_default_slave u_default_slave (
        .clk          (HCLK),
        .rst          (HRESET),
        .hready       (HREADY),
        .trans_active (trans_active),
        .hit_any      (hit_any),
        .ready        (ds_ready),
        .resp         (ds_resp),
        .err_start_c  (err_start_c)
    );

    // Response source is frozen for the whole data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_sel <= '0;
        end else if (HREADY) begin
            dp_sel <= S_HSEL;
        end
    end

    always_comb begin
        rsp = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            rsp.ready = rsp.ready | (dp_sel[i] & S_HREADYOUT[i]);
            rsp.resp  = rsp.resp  | (dp_sel[i] & S_HRESP[i]);
            rsp.rdata = rsp.rdata | ({DATA_W{dp_sel[i]}} & S_HRDATA[DATA_W*i +: DATA_W]);
        end
        if (dp_sel == '0) begin
            rsp.ready = ds_ready;
            rsp.resp  = ds_resp;
        end
    end

    assign HREADY = rsp.ready;
    assign HRESP  = rsp.resp;
    assign HRDATA = rsp.rdata;

    // Error log: a new error overrides a coincident clear
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ERR_COUNT <= '0;
            ERR_ADDR  <= '0;
        end else if (err_start_c) begin
            ERR_ADDR <= HADDR;
            if (ERR_CLR) begin
                ERR_COUNT <= ERR_CNT_W'(1);
            end else if (ERR_COUNT != {ERR_CNT_W{1'b1}}) begin
                ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
            end
        end else if (ERR_CLR) begin
            ERR_COUNT <= '0;
            ERR_ADDR  <= '0;
        end
    end

endmodule
